// File: rtl/adc_burst_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module   : adc_burst_scheduler_if
// Purpose  : FIFO read side and PSRAM write-burst side of the ADC burst
//            scheduler, bundled so the scheduler and its neighbours share one
//            set of signal names.
// Revision : 1.0 - initial release
// ============================================================================
interface adc_burst_scheduler_if #(
    parameter int DATA_WIDTH = 16,
    parameter int LVL_W      = 8,
    parameter int ADDR_W     = 22
);
    // FIFO side
    logic [LVL_W-1:0]      fifo_level;
    logic                  fifo_empty;
    logic                  fifo_rd_en;
    logic [DATA_WIDTH-1:0] fifo_data;

    // PSRAM controller side
    logic                  mem_req;
    logic                  mem_ack;
    logic                  mem_busy;
    logic [ADDR_W-1:0]     mem_addr;
    logic [LVL_W-1:0]      mem_len;
    logic                  mem_wvalid;
    logic [DATA_WIDTH-1:0] mem_wdata;

    // Scheduler view
    modport master (
        input  fifo_level,
        input  fifo_empty,
        input  fifo_data,
        input  mem_ack,
        input  mem_busy,
        output fifo_rd_en,
        output mem_req,
        output mem_addr,
        output mem_len,
        output mem_wvalid,
        output mem_wdata
    );

    // FIFO + memory controller view
    modport slave (
        output fifo_level,
        output fifo_empty,
        output fifo_data,
        output mem_ack,
        output mem_busy,
        input  fifo_rd_en,
        input  mem_req,
        input  mem_addr,
        input  mem_len,
        input  mem_wvalid,
        input  mem_wdata
    );
endinterface
`default_nettype wire

// File: rtl/adc_burst_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : adc_burst_scheduler
// Purpose  : Drains the ADC sample FIFO into PSRAM in fixed-length write
//            bursts and flushes the remainder when acquisition stops.
// Revision : 1.0 - initial release
// ============================================================================
module adc_burst_scheduler #(
    parameter int DATA_WIDTH = 16,
    parameter int LVL_W      = 8,
    parameter int BURST_LEN  = 16,
    parameter int ADDR_W     = 22,
    parameter int MEM_WORDS  = 4194304
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    input  wire logic             acq_en_i,
    adc_burst_scheduler_if.master bus,
    output logic                  wrapped_o,
    output logic                  flush_done_o
);

    localparam logic [LVL_W-1:0]      C_BURST_LEN = LVL_W'(BURST_LEN);
    localparam logic [ADDR_W:0]       C_MEM_WORDS = (ADDR_W+1)'(MEM_WORDS);
    localparam logic [LVL_W-1:0]      C_ONE       = LVL_W'(1);
    localparam logic [DATA_WIDTH-1:0] C_ZERO_DATA = '0;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_REQ    = 3'd1,
        S_STREAM = 3'd2,
        S_DRAIN  = 3'd3,
        S_SETTLE = 3'd4
    } state_t;

    state_t            state_q;
    logic              acq_q;
    logic              flush_pending_q;
    logic              flush_burst_q;
    logic              settle_q;
    logic [LVL_W-1:0]  pop_cnt_q;
    logic [LVL_W-1:0]  mem_len_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic              mem_req_q;
    logic              rd_en_q;
    logic              wvalid_q;
    logic              wrapped_q;
    logic              flush_done_q;

    logic              acq_fall_d;
    logic [ADDR_W:0]   addr_sum_d;
    logic              addr_wrap_d;
    logic [ADDR_W-1:0] addr_next_d;
    logic              full_ready_d;
    logic              flush_ready_d;

    // The sum is one bit wider so that a start address near the top of a
    // full 2^ADDR_W space cannot overflow before the wrap compare.
    always_comb begin
        acq_fall_d    = acq_q & ~acq_en_i;
        addr_sum_d    = {1'b0, mem_addr_q} + (ADDR_W+1)'(mem_len_q);
        addr_wrap_d   = (addr_sum_d >= C_MEM_WORDS);
        addr_next_d   = addr_wrap_d ? ADDR_W'(addr_sum_d - C_MEM_WORDS)
                                    : ADDR_W'(addr_sum_d);
        full_ready_d  = acq_en_i && !bus.fifo_empty &&
                        (bus.fifo_level >= C_BURST_LEN);
        flush_ready_d = flush_pending_q && !bus.fifo_empty &&
                        (bus.fifo_level != '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= S_IDLE;
            acq_q           <= 1'b0;
            flush_pending_q <= 1'b0;
            flush_burst_q   <= 1'b0;
            settle_q        <= 1'b0;
            pop_cnt_q       <= '0;
            mem_len_q       <= '0;
            mem_addr_q      <= '0;
            mem_req_q       <= 1'b0;
            rd_en_q         <= 1'b0;
            wvalid_q        <= 1'b0;
            wrapped_q       <= 1'b0;
            flush_done_q    <= 1'b0;
        end else begin
            acq_q        <= acq_en_i;
            wvalid_q     <= rd_en_q;
            flush_done_q <= 1'b0;

            case (state_q)
                S_IDLE: begin
                    if (full_ready_d) begin
                        mem_len_q     <= C_BURST_LEN;
                        flush_burst_q <= 1'b0;
                        mem_req_q     <= 1'b1;
                        state_q       <= S_REQ;
                    end else if (flush_ready_d) begin
                        mem_len_q     <= bus.fifo_level;
                        flush_burst_q <= 1'b1;
                        mem_req_q     <= 1'b1;
                        state_q       <= S_REQ;
                    end else if (flush_pending_q && bus.fifo_empty) begin
                        flush_done_q    <= 1'b1;
                        flush_pending_q <= 1'b0;
                    end
                end

                S_REQ: begin
                    if (bus.mem_ack) begin
                        mem_req_q <= 1'b0;
                        rd_en_q   <= 1'b1;
                        pop_cnt_q <= '0;
                        state_q   <= S_STREAM;
                    end
                end

                S_STREAM: begin
                    if (pop_cnt_q == (mem_len_q - C_ONE)) begin
                        rd_en_q <= 1'b0;
                        state_q <= S_DRAIN;
                    end else begin
                        pop_cnt_q <= pop_cnt_q + C_ONE;
                    end
                end

                // The final beat leaves wvalid_q the cycle after the last pop.
                S_DRAIN: begin
                    if (!wvalid_q && !bus.mem_busy) begin
                        mem_addr_q <= addr_next_d;
                        if (addr_wrap_d) begin
                            wrapped_q <= 1'b1;
                        end
                        settle_q <= 1'b0;
                        state_q  <= S_SETTLE;
                    end
                end

                // Two idle cycles let the registered FIFO level catch up.
                S_SETTLE: begin
                    if (settle_q) begin
                        state_q <= S_IDLE;
                        if (flush_burst_q) begin
                            flush_done_q    <= 1'b1;
                            flush_pending_q <= 1'b0;
                        end
                    end else begin
                        settle_q <= 1'b1;
                    end
                end

                default: begin
                    state_q <= S_IDLE;
                end
            endcase

            // A fresh stop edge re-arms the flush even if one just finished.
            if (acq_fall_d) begin
                flush_pending_q <= 1'b1;
            end
        end
    end

    assign bus.fifo_rd_en = rd_en_q;
    assign bus.mem_req    = mem_req_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_len    = mem_len_q;
    assign bus.mem_wvalid = wvalid_q;
    // FIFO read data lands in the same cycle as wvalid; gate it so the bus
    // reads zero outside a beat and during reset.
    assign bus.mem_wdata  = wvalid_q ? bus.fifo_data : C_ZERO_DATA;
    assign wrapped_o      = wrapped_q;
    assign flush_done_o   = flush_done_q;

endmodule
`default_nettype wire

// File: tb/tb_adc_burst_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_adc_burst_scheduler
// Purpose  : Directed bench with a FIFO / PSRAM-controller model and a
//            burst-level scoreboard for adc_burst_scheduler.
// Revision : 1.0 - initial release
// ============================================================================
module tb_adc_burst_scheduler;

    localparam int DW = 16;
    localparam int LW = 8;
    localparam int BL = 16;
    localparam int AW = 22;
    localparam int MW = 40;

    logic clk    = 1'b0;
    logic rst_n  = 1'b0;
    logic acq_en = 1'b0;
    logic wrapped;
    logic flush_done;

    adc_burst_scheduler_if #(.DATA_WIDTH(DW), .LVL_W(LW), .ADDR_W(AW)) bus ();

    adc_burst_scheduler #(
        .DATA_WIDTH(DW), .LVL_W(LW), .BURST_LEN(BL), .ADDR_W(AW), .MEM_WORDS(MW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .acq_en_i     (acq_en),
        .bus          (bus),
        .wrapped_o    (wrapped),
        .flush_done_o (flush_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- FIFO model (registered level/empty/data) -------------
    logic          wr_en   = 1'b0;
    logic [DW-1:0] wr_data = '0;
    logic [DW-1:0] fq[$];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fq.delete();
            bus.fifo_data  <= '0;
            bus.fifo_level <= '0;
            bus.fifo_empty <= 1'b1;
        end else begin
            if (bus.fifo_rd_en && fq.size() > 0) bus.fifo_data <= fq.pop_front();
            if (wr_en) fq.push_back(wr_data);
            bus.fifo_level <= LW'(fq.size());
            bus.fifo_empty <= (fq.size() == 0);
        end
    end

    // ---------------- PSRAM controller model -------------------------------
    int ack_dly   = 3;
    int busy_hold = 0;
    int req_cnt;
    int busy_cnt;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_cnt     <= 0;
            bus.mem_ack <= 1'b0;
            busy_cnt    <= 0;
        end else begin
            if (bus.mem_req && !bus.mem_ack) begin
                req_cnt     <= req_cnt + 1;
                bus.mem_ack <= (req_cnt == ack_dly - 2);
            end else begin
                req_cnt     <= 0;
                bus.mem_ack <= 1'b0;
            end
            if (bus.mem_wvalid)  busy_cnt <= busy_hold;
            else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
        end
    end
    assign bus.mem_busy = (busy_cnt != 0);

    // ---------------- scoreboard state --------------------------------------
    int errors = 0;
    int checks = 0;

    logic [DW-1:0] sent_q[$];
    int  m_addr;
    bit  m_wrap;
    bit  in_burst;
    int  b_len, b_addr, beats;
    int  req_rises, bursts_done, fd_cnt, req_hi;
    int  ack_cyc, last_wv_cyc;
    int  addr_log[8];
    int  len_log[8];
    int  first_w, last_w;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic clear_model();
        sent_q.delete();
        m_addr = 0; m_wrap = 0; in_burst = 0;
        req_rises = 0; bursts_done = 0; fd_cnt = 0; req_hi = 0;
    endtask

    // Burst-level model: every request must start at the model's wrapping
    // address with min(BURST_LEN, outstanding samples) words, and the beats
    // must replay the written samples in order.
    initial begin : compare
        bit req_prev, fd_prev;
        int exp_len, sum;
        req_prev = 0; fd_prev = 0; ack_cyc = -100;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                req_prev = 0; fd_prev = 0;
                continue;
            end
            if (bus.mem_req && !req_prev) begin
                exp_len = (sent_q.size() >= BL) ? BL : sent_q.size();
                chk("req_addr", bus.mem_addr, m_addr);
                chk("req_len", bus.mem_len, exp_len);
                chk("req_wrapped", wrapped, m_wrap);
                chk("req_overlap", in_burst, 0);
                if (acq_en) chk("req_full_only", bus.mem_len, BL);
                if (req_rises < 8) begin
                    addr_log[req_rises] = int'(bus.mem_addr);
                    len_log[req_rises]  = int'(bus.mem_len);
                end
                req_rises++;
                in_burst = 1; b_len = int'(bus.mem_len); b_addr = int'(bus.mem_addr);
                beats = 0; req_hi = 0; ack_cyc = -100;
            end else if (in_burst) begin
                chk("addr_stable", bus.mem_addr, b_addr);
                chk("len_stable", bus.mem_len, b_len);
            end
            if (bus.mem_req) req_hi++;
            if (bus.mem_ack && in_burst) ack_cyc = cyc;
            if (bus.fifo_rd_en) chk("pop_nonempty", fq.size() > 0, 1);

            if (bus.mem_wvalid) begin
                chk("wvalid_in_burst", in_burst, 1);
                if (in_burst) begin
                    if (beats == 0) chk("ack_to_wvalid", cyc - ack_cyc, 2);
                    if (sent_q.size() == 0) begin
                        chk("wdata_available", sent_q.size(), 1);
                    end else begin
                        if (beats == 0) first_w = int'(bus.mem_wdata);
                        last_w = int'(bus.mem_wdata);
                        chk("wdata", bus.mem_wdata, sent_q.pop_front());
                    end
                    beats++;
                    if (beats == b_len) begin
                        sum = m_addr + b_len;
                        if (sum >= MW) begin
                            sum -= MW;
                            m_wrap = 1;
                        end
                        m_addr = sum;
                        in_burst = 0;
                        bursts_done++;
                        last_wv_cyc = cyc;
                    end
                end
            end else if (in_burst && beats > 0) begin
                chk("wvalid_contig", bus.mem_wvalid, 1);
            end

            if (flush_done) begin
                fd_cnt++;
                chk("flush_done_width", fd_prev, 0);
                chk("flush_done_idle", in_burst, 0);
            end
            fd_prev  = flush_done;
            req_prev = bus.mem_req;
        end
    end

    // ---------------- stimulus helpers --------------------------------------
    task automatic push(input int n, input int base);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            wr_en   = 1'b1;
            wr_data = DW'(base + i);
            sent_q.push_back(DW'(base + i));
        end
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic wait_done(input int nb, input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (bursts_done >= nb) break;
        end
        chk("bursts_completed", bursts_done, nb);
        repeat (8) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1;
        rst_n = 1'b0; acq_en = 1'b0; wr_en = 1'b0;
        clear_model();
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_rd_en"},   bus.fifo_rd_en, 0);
        chk({tag, "_req"},     bus.mem_req, 0);
        chk({tag, "_addr"},    bus.mem_addr, 0);
        chk({tag, "_len"},     bus.mem_len, 0);
        chk({tag, "_wvalid"},  bus.mem_wvalid, 0);
        chk({tag, "_wdata"},   bus.mem_wdata, 0);
        chk({tag, "_wrapped"}, wrapped, 0);
        chk({tag, "_fdone"},   flush_done, 0);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // ---------------- directed sequence -------------------------------------
    initial begin : main
        int pops, b, gap;
        clear_model();
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        #1 rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Reset asserted asynchronously at pop index 5 of a 16-word burst.
        acq_en = 1'b1;
        push(16, 'h0200);
        pops = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (bus.fifo_rd_en) pops++;
            if (pops == 6) break;
        end
        chk("midreset_reached_pop5", pops, 6);
        #1 rst_n = 1'b0;
        clear_model();
        #1 chk_all_zero("midreset");
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b1;
        repeat (6) @(negedge clk);
        chk("post_reset_no_req", req_rises, 0);
        chk("post_reset_addr", bus.mem_addr, 0);

        // Single burst.
        push(16, 'h0100);
        wait_done(1, 200);
        chk("single_req_cycles", req_hi, 3);
        chk("single_len", len_log[0], 16);
        chk("single_start", addr_log[0], 0);
        chk("single_first_data", first_w, 'h0100);
        chk("single_last_data", last_w, 'h010F);
        chk("single_next_addr", bus.mem_addr, 16);

        // Back-to-back, then flush of the 8-word remainder.
        do_reset();
        acq_en = 1'b1;
        push(40, 'h1000);
        wait_done(2, 400);
        repeat (30) @(negedge clk);
        chk("b2b_requests", req_rises, 2);
        chk("b2b_addr1", addr_log[1], 16);
        chk("b2b_remaining", fq.size(), 8);
        acq_en = 1'b0;
        wait_done(3, 200);
        chk("flush_requests", req_rises, 3);
        chk("flush_addr", addr_log[2], 32);
        chk("flush_len", len_log[2], 8);
        chk("flush_done_count", fd_cnt, 1);
        chk("flush_fifo_empty", fq.size(), 0);
        chk("flush_wrap_addr", bus.mem_addr, 0);
        chk("flush_wrapped", wrapped, 1);
        acq_en = 1'b1;
        repeat (4) @(negedge clk);
        acq_en = 1'b0;
        repeat (10) @(negedge clk);
        chk("empty_flush_done", fd_cnt, 2);
        chk("empty_flush_no_req", req_rises, 3);

        // Wrap with MEM_WORDS=40.
        do_reset();
        acq_en = 1'b1;
        push(48, 'h2000);
        wait_done(3, 500);
        chk("wrap_addr0", addr_log[0], 0);
        chk("wrap_addr1", addr_log[1], 16);
        chk("wrap_addr2", addr_log[2], 32);
        chk("wrap_next_addr", bus.mem_addr, 8);
        chk("wrap_flag", wrapped, 1);

        // Busy hold after the last beat of the first burst.
        do_reset();
        busy_hold = 10;
        acq_en = 1'b1;
        push(32, 'h3000);
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (bursts_done >= 1) break;
        end
        chk("busy_first_burst", bursts_done, 1);
        b = -1;
        for (int i = 0; i < 100; i++) begin
            if (!bus.mem_busy) begin
                b = cyc;
                break;
            end
            chk("busy_no_req", bus.mem_req, 0);
            @(negedge clk);
        end
        chk("busy_len", b - last_wv_cyc - 1, 10);
        gap = -1;
        for (int i = 0; i < 20; i++) begin
            if (bus.mem_req) begin
                gap = cyc - b;
                break;
            end
            @(negedge clk);
        end
        chk("busy_gap_min", gap >= 3, 1);
        chk("busy_gap_max", gap <= 6, 1);
        busy_hold = 0;
        wait_done(2, 200);
        chk("busy_second_addr", addr_log[1], 16);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
